mac_accum_stage: RTL and testbench

Accumulator/output stage of the 16-bit MAC datapath. Sits directly downstream of the adder-B input mux. Takes the selected B operand plus an A operand or accumulator feedback, then adds or subtracts with carry-in. Registers the result, carry/borrow and a sticky overflow flag, and drives the block's output bus.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_addsub.sv | 31 +++
 rtl/mac_accum_stage.sv | 147 ++++++++++++++
 tb/tb_mac_accum_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: default width, add/sub encodings,
// signed saturation limits and the control bundle carried through the input stage.
package mac_pkg;

   localparam int MAC_WIDTH = 16;

   localparam logic MAC_OP_ADD = 1'b0;
   localparam logic MAC_OP_SUB = 1'b1;

   localparam logic [MAC_WIDTH-1:0] MAC_SMAX = 16'h7FFF;
   localparam logic [MAC_WIDTH-1:0] MAC_SMIN = 16'h8000;

   typedef struct packed {
      logic load;
      logic hold;
      logic acc_en;
      logic addsub;
      logic ci;
   } mac_ctrl_t;

endpackage

// File: rtl/mac_addsub.sv
// Combinational add/subtract core: sum, carry/borrow-out and signed overflow event.
module mac_addsub
   import mac_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_addsub,
   input  logic             i_ci,
   output logic [WIDTH-1:0] o_s,
   output logic             o_co,
   output logic             o_ovf_s
);

   logic             w_sub;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;

   assign w_sub = (i_addsub == MAC_OP_SUB);
   assign w_b   = w_sub ? ~i_b : i_b;
   assign w_cin = w_sub ? ~i_ci : i_ci;
   assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

   assign o_s  = w_sum[WIDTH-1:0];
   // Subtract reports borrow, i.e. the inverted carry of A + ~B + ~CI.
   assign o_co = w_sum[WIDTH] ^ w_sub;
   assign o_ovf_s = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/mac_accum_stage.sv
// Accumulator/output stage of the MAC datapath: optional input register, LOAD/HOLD/accumulate
// priority, carry and sticky overflow. Define MAC_ACCUM_SAT_EN to clamp on overflow events.
module mac_accum_stage
   import mac_pkg::*;
#(
   parameter int WIDTH  = MAC_WIDTH,
   parameter bit IN_REG = 1'b1,
   parameter bit SIGNED = 1'b0
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE,
   input  logic             VALID_IN,
   input  logic [WIDTH-1:0] ADDER_A,
   input  logic [WIDTH-1:0] ADDER_B_MUX,
   input  logic [WIDTH-1:0] LOAD_DATA,
   input  logic             ACC_EN,
   input  logic             ADDSUB,
   input  logic             CI,
   input  logic             LOAD,
   input  logic             HOLD,
   output logic [WIDTH-1:0] O,
   output logic             CO,
   output logic             OVF,
   output logic             VALID_OUT
);

   mac_ctrl_t        w_ctrl_in;
   mac_ctrl_t        w_ctrl;
   logic             w_vld;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_ld;

   logic [WIDTH-1:0] r_o;
   logic             r_co;
   logic             r_ovf;
   logic             r_vld_out;

   assign w_ctrl_in = '{load: LOAD, hold: HOLD, acc_en: ACC_EN, addsub: ADDSUB, ci: CI};

   generate
      if (IN_REG) begin : g_in_reg
         logic             r_vld;
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_b;
         logic [WIDTH-1:0] r_ld;
         mac_ctrl_t        r_ctrl;

         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               r_vld  <= 1'b0;
               r_a    <= '0;
               r_b    <= '0;
               r_ld   <= '0;
               r_ctrl <= '0;
            end else if (CE) begin
               r_vld  <= VALID_IN;
               r_a    <= ADDER_A;
               r_b    <= ADDER_B_MUX;
               r_ld   <= LOAD_DATA;
               r_ctrl <= w_ctrl_in;
            end
         end

         assign w_vld  = r_vld;
         assign w_a    = r_a;
         assign w_b    = r_b;
         assign w_ld   = r_ld;
         assign w_ctrl = r_ctrl;
      end else begin : g_in_comb
         assign w_vld  = VALID_IN;
         assign w_a    = ADDER_A;
         assign w_b    = ADDER_B_MUX;
         assign w_ld   = LOAD_DATA;
         assign w_ctrl = w_ctrl_in;
      end
   endgenerate

   // Operation stage: feedback takes O as it stands at this edge, so accumulation has no bubble.
   logic [WIDTH-1:0] w_a_op;
   logic [WIDTH-1:0] w_s;
   logic             w_co;
   logic             w_ovf_s;
   logic             w_evt;
   logic [WIDTH-1:0] w_res;

   assign w_a_op = w_ctrl.acc_en ? r_o : w_a;

   mac_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a      (w_a_op),
      .i_b      (w_b),
      .i_addsub (w_ctrl.addsub),
      .i_ci     (w_ctrl.ci),
      .o_s      (w_s),
      .o_co     (w_co),
      .o_ovf_s  (w_ovf_s)
   );

   assign w_evt = SIGNED ? w_ovf_s : w_co;

`ifdef MAC_ACCUM_SAT_EN
   localparam logic [WIDTH-1:0] L_SMAX = (WIDTH == MAC_WIDTH) ? WIDTH'(MAC_SMAX) : {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] L_SMIN = (WIDTH == MAC_WIDTH) ? WIDTH'(MAC_SMIN) : {1'b1, {(WIDTH-1){1'b0}}};

   // Signed overflow direction follows A's sign, since A and B' shared it.
   function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] s, input logic evt,
                                                input logic sub, input logic a_msb);
      if (!evt) return s;
      if (SIGNED) return a_msb ? L_SMIN : L_SMAX;
      return sub ? '0 : '1;
   endfunction

   assign w_res = f_clamp(w_s, w_evt, (w_ctrl.addsub == MAC_OP_SUB), w_a_op[WIDTH-1]);
`else
   assign w_res = w_s;
`endif

   // Output stage: LOAD beats HOLD beats accumulate, only on valid enabled edges.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_o       <= '0;
         r_co      <= 1'b0;
         r_ovf     <= 1'b0;
         r_vld_out <= 1'b0;
      end else if (CE) begin
         r_vld_out <= w_vld;
         if (w_vld) begin
            if (w_ctrl.load) begin
               r_o   <= w_ld;
               r_co  <= 1'b0;
               r_ovf <= 1'b0;
            end else if (!w_ctrl.hold) begin
               r_o   <= w_res;
               r_co  <= w_co;
               r_ovf <= r_ovf | w_evt;
            end
         end
      end
   end

   assign O         = r_o;
   assign CO        = r_co;
   assign OVF       = r_ovf;
   assign VALID_OUT = r_vld_out;

endmodule

// File: tb/tb_mac_accum_stage.sv
// Scoreboard bench for mac_accum_stage: an unsigned registered-input instance and a signed
// combinational-input instance share stimulus; each has its own expected-result queue.
module tb_mac_accum_stage;

   typedef struct packed {
      logic [15:0] o;
      logic        co;
      logic        ovf;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        CE = 1'b0;
   logic        VALID_IN = 1'b0;
   logic [15:0] ADDER_A = '0;
   logic [15:0] ADDER_B_MUX = '0;
   logic [15:0] LOAD_DATA = '0;
   logic        ACC_EN = 1'b0;
   logic        ADDSUB = 1'b0;
   logic        CI = 1'b0;
   logic        LOAD = 1'b0;
   logic        HOLD = 1'b0;

   logic [15:0] o_u, o_s;
   logic        co_u, co_s, ovf_u, ovf_s, vo_u, vo_s;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q_exp [2][$];
   exp_t m_st [2];
   exp_t prev [2];
   bit   skip = 1'b1;
   bit   ce_last = 1'b0;

   always #5 CLK = ~CLK;

   mac_accum_stage #(.WIDTH(16), .IN_REG(1'b1), .SIGNED(1'b0)) u_dut_u (
      .CLK(CLK), .RSTN(RSTN), .CE(CE), .VALID_IN(VALID_IN), .ADDER_A(ADDER_A),
      .ADDER_B_MUX(ADDER_B_MUX), .LOAD_DATA(LOAD_DATA), .ACC_EN(ACC_EN), .ADDSUB(ADDSUB),
      .CI(CI), .LOAD(LOAD), .HOLD(HOLD), .O(o_u), .CO(co_u), .OVF(ovf_u), .VALID_OUT(vo_u));

   mac_accum_stage #(.WIDTH(16), .IN_REG(1'b0), .SIGNED(1'b1)) u_dut_s (
      .CLK(CLK), .RSTN(RSTN), .CE(CE), .VALID_IN(VALID_IN), .ADDER_A(ADDER_A),
      .ADDER_B_MUX(ADDER_B_MUX), .LOAD_DATA(LOAD_DATA), .ACC_EN(ACC_EN), .ADDSUB(ADDSUB),
      .CI(CI), .LOAD(LOAD), .HOLD(HOLD), .O(o_s), .CO(co_s), .OVF(ovf_s), .VALID_OUT(vo_s));

   // Reference: arithmetic on plain integers, then the accumulator rules.
   function automatic exp_t model_step(input exp_t st, input bit sgn, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] ld, input logic acc_en,
                                       input logic sub, input logic ci, input logic load, input logic hold);
      exp_t        nx;
      logic [15:0] av;
      int          ua, ub, sa, sb, c, full, sr;
      bit          sov, evt;
      nx = st;
      if (load) begin
         nx.o = ld; nx.co = 1'b0; nx.ovf = 1'b0;
         return nx;
      end
      if (hold) return nx;
      av = acc_en ? st.o : a;
      ua = int'(av);
      ub = int'(b);
      sa = int'($signed(av));
      sb = int'($signed(b));
      c  = ci ? 1 : 0;
      if (!sub) begin
         full = ua + ub + c; nx.co = (full > 65535); sr = sa + sb + c;
      end else begin
         full = ua - ub - c; nx.co = (full < 0); sr = sa - sb - c;
      end
      nx.o = full[15:0];
      sov  = (sr > 32767) || (sr < -32768);
      evt  = sgn ? sov : nx.co;
`ifdef MAC_ACCUM_SAT_EN
      if (evt) nx.o = sgn ? ((sr > 0) ? 16'h7FFF : 16'h8000) : (sub ? 16'h0000 : 16'hFFFF);
`endif
      nx.ovf = st.ovf | evt;
      return nx;
   endfunction

   task automatic chk(input string name, input int k, input logic [18:0] got, input logic [18:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d: got VO/O/CO/OVF=%b/%h/%b/%b want %b/%h/%b/%b at %0t", name, k,
                  got[18], got[17:2], got[1], got[0], want[18], want[17:2], want[1], want[0], $time);
      end
   endtask

   task automatic drive(input logic ce, input logic vld, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ld, input logic acc, input logic sub, input logic ci,
                        input logic load, input logic hold);
      CE = ce; VALID_IN = vld; ADDER_A = a; ADDER_B_MUX = b; LOAD_DATA = ld;
      ACC_EN = acc; ADDSUB = sub; CI = ci; LOAD = load; HOLD = hold;
      if (ce && vld) begin
         for (int k = 0; k < 2; k++) begin
            m_st[k] = model_step(m_st[k], (k == 1), a, b, ld, acc, sub, ci, load, hold);
            q_exp[k].push_back(m_st[k]);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_now(input string name);
      chk(name, 0, {vo_u, o_u, co_u, ovf_u}, 19'd0);
      chk(name, 1, {vo_s, o_s, co_s, ovf_s}, 19'd0);
   endtask

   task automatic reset_mid();
      #1;
      RSTN = 1'b0;
      VALID_IN = 1'b0;
      #1;
      check_reset_now("reset_mid");
      for (int k = 0; k < 2; k++) begin
         q_exp[k].delete();
         m_st[k] = '0;
      end
      skip = 1'b1;
      #1;
      RSTN = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   always @(posedge CLK) ce_last <= CE;

   // Monitor: pops on every fresh VALID_OUT, otherwise insists the outputs stay put.
   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         exp_t got;
         logic v;
         exp_t e;
         got = (k == 0) ? {o_u, co_u, ovf_u} : {o_s, co_s, ovf_s};
         v   = (k == 0) ? vo_u : vo_s;
         if (!skip && RSTN) begin
            if (v && ce_last) begin
               if (q_exp[k].size() == 0) begin
                  chk("unexpected_valid", k, {1'b1, got}, {1'b0, got});
               end else begin
                  e = q_exp[k].pop_front();
                  chk("result", k, {1'b1, got}, {1'b1, e});
               end
            end else begin
               chk("idle_stable", k, {1'b0, got}, {1'b0, prev[k]});
            end
         end
         prev[k] = got;
      end
      skip = 1'b0;
   end

   initial begin
      m_st[0] = '0; m_st[1] = '0;
      prev[0] = '0; prev[1] = '0;
      #3;
      check_reset_now("reset_state");
      #1;
      RSTN = 1'b1;
      @(posedge CLK);
      #1;

      // Load then accumulate +5 three times.
      drive(1, 1, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) drive(1, 1, 16'h0000, 16'h0005, 16'h0000, 1, 0, 0, 0, 0);
      // Unsigned carry and borrow wrap.
      drive(1, 1, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
      drive(1, 1, 16'h0000, 16'h0001, 16'h0000, 0, 1, 0, 0, 0);
      // Signed overflow, sticky through in-range ops, cleared by LOAD.
      drive(1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0);
      drive(1, 1, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
      drive(1, 1, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
      drive(1, 1, 16'h0003, 16'h0001, 16'h0000, 0, 1, 0, 0, 0);
      drive(1, 1, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 1, 0);
      // LOAD wins over HOLD, then HOLD freezes for four valid ops.
      drive(1, 1, 16'h1111, 16'h2222, 16'h1234, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) drive(1, 1, rnd16(), rnd16(), 16'h0000, 1, 0, 1, 0, 1);
      // CE low for two cycles stalls the op in flight.
      drive(1, 1, 16'h0000, 16'h0007, 16'h0000, 1, 0, 1, 0, 0);
      drive(0, 1, 16'hAAAA, 16'h5555, 16'h0000, 0, 1, 1, 1, 0);
      drive(0, 1, 16'hAAAA, 16'h5555, 16'h0000, 0, 1, 1, 1, 0);
      drive(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
      drive(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
      // Reset in the middle of accumulation.
      drive(1, 1, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0, 0, 0);
      drive(1, 1, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0, 0, 0);
      reset_mid();

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), rnd16(), rnd16(), rnd16(),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
      end

      for (int i = 0; i < 4; i++) drive(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++)
         chk("drained", k, {3'b000, 16'(q_exp[k].size())}, 19'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
